led_sel_ctrl: RTL

Parametrised LED select controller that drives one of `NUM_LED` indicator LEDs chosen by a binary select code. It is the successor to the fixed 2-bit combinational LED decoder. It adds registered configuration, an enable gate, and four display modes: steady, blink, PWM dim and chase. It sits between the user-input/datapath logic and the board LED pins.

---
 rtl/led_sel_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/led_sel_ctrl.sv
// LED select controller: drives one of NUM_LED outputs from a loaded select code,
// with steady, blink, PWM-dim and chase display modes and a global enable gate.
module led_sel_ctrl #(
    parameter int NUM_LED   = 4,
    parameter int SEL_W     = 2,
    parameter int BLINK_DIV = 4,
    parameter int PWM_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   dataIn,
    input  logic [1:0]         mode,
    input  logic [PWM_W-1:0]   duty,
    input  logic               load,
    input  logic               ledOn,
    output logic [NUM_LED-1:0] led
);

    localparam int PRE_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_STEADY = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_DIM    = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

    logic [SEL_W-1:0]   r_sel;
    mode_e              r_mode;
    logic [PWM_W-1:0]   r_duty;
    logic [PRE_W-1:0]   r_pre;
    logic               r_ph;
    logic [SEL_W-1:0]   r_pos;
    logic [PWM_W-1:0]   r_pc;
    logic [NUM_LED-1:0] r_led;

    logic               w_tick;
    logic               w_sel_ok;
    logic               w_load_sel_ok;
    logic               w_bit_on;
    logic [NUM_LED-1:0] w_led_next;

    assign w_tick        = (r_pre == PRE_W'(BLINK_DIV - 1));
    assign w_sel_ok      = (32'(r_sel) < NUM_LED);
    assign w_load_sel_ok = (32'(dataIn) < NUM_LED);

    // Level applied to the selected LED in the non-chase modes.
    always_comb begin
        w_bit_on = 1'b0;
        case (r_mode)
            MODE_STEADY: w_bit_on = 1'b1;
            MODE_BLINK:  w_bit_on = r_ph;
            MODE_DIM:    w_bit_on = (r_pc < r_duty);
            default:     w_bit_on = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_led
            assign w_led_next[gi] = ledOn &
                ((r_mode == MODE_CHASE) ? (r_pos == SEL_W'(gi))
                                        : (w_sel_ok & (r_sel == SEL_W'(gi)) & w_bit_on));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= '0;
            r_mode <= MODE_STEADY;
            r_duty <= '0;
            r_pre  <= '0;
            r_ph   <= 1'b1;
            r_pos  <= '0;
            r_pc   <= '0;
            r_led  <= '0;
        end else begin
            r_pc  <= r_pc + PWM_W'(1);
            r_led <= w_led_next;
            // A load restarts the blink/chase timebase and overrides a coincident tick.
            if (load) begin
                r_sel  <= dataIn;
                r_mode <= mode_e'(mode);
                r_duty <= duty;
                r_pre  <= '0;
                r_ph   <= 1'b1;
                r_pos  <= w_load_sel_ok ? dataIn : '0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_ph  <= ~r_ph;
                r_pos <= (r_pos == SEL_W'(NUM_LED - 1)) ? '0 : r_pos + SEL_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    assign led = r_led;

endmodule
